branch_unit: RTL

Sequential branch-resolution stage for the KGP-RISC core. Generalises the combinational branch decision in three ways: registered condition flags, 8 encoded conditions, and parametrised datapath width. Owns the PC register and computes relative or absolute targets. Emits a one-cycle flush on a taken branch, a link write for calls, and a saturating taken-branch counter. Sits between decode/ALU and instruction fetch.

---
 rtl/kgp_branch_pkg.sv | 14 +
 rtl/branch_unit_if.sv | 26 ++
 rtl/branch_cond.sv | 25 ++
 rtl/branch_unit.sv | 63 ++++++
 4 files changed

// File: rtl/kgp_branch_pkg.sv
// kgp_branch_pkg: condition codes and flag bit positions for the KGP-RISC branch unit
package kgp_branch_pkg;
    localparam logic [2:0] COND_NEVER  = 3'b000;
    localparam logic [2:0] COND_BCY    = 3'b001;
    localparam logic [2:0] COND_BNC    = 3'b010;
    localparam logic [2:0] COND_BZ     = 3'b011;
    localparam logic [2:0] COND_BNZ    = 3'b100;
    localparam logic [2:0] COND_BLTZ   = 3'b101;
    localparam logic [2:0] COND_BGTZ   = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;
endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: branch request from decode and PC/flush/link results back to fetch and regfile
//   br_valid/br_cond/br_abs/br_link/br_off/br_reg : branch request (master -> slave)
//   pc/flush/link_we/link_data                    : results (slave -> master)
interface branch_unit_if #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 22
) ();
    logic              br_valid;
    logic [2:0]        br_cond;
    logic              br_abs;
    logic              br_link;
    logic [OFF_W-1:0]  br_off;
    logic [DATA_W-1:0] br_reg;
    logic [DATA_W-1:0] pc;
    logic              flush;
    logic              link_we;
    logic [DATA_W-1:0] link_data;
    modport master (
        output br_valid, br_cond, br_abs, br_link, br_off, br_reg,
        input  pc, flush, link_we, link_data
    );
    modport slave (
        input  br_valid, br_cond, br_abs, br_link, br_off, br_reg,
        output pc, flush, link_we, link_data
    );
endinterface

// File: rtl/branch_cond.sv
// branch_cond: decodes a 3-bit condition code against {carry, zero, neg} into a taken decision
//   cond : condition code, carry/zero/neg : effective flags, taken : branch decision
module branch_cond
    import kgp_branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       carry,
    input  logic       zero,
    input  logic       neg,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BCY:    taken = carry;
            COND_BNC:    taken = !carry;
            COND_BZ:     taken = zero;
            COND_BNZ:    taken = !zero;
            COND_BLTZ:   taken = neg;
            COND_BGTZ:   taken = !neg && !zero;
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_unit.sv
// branch_unit: sequential branch resolution, PC register, flag register, link and taken counter
//   clk/rst_n : clock, async active-low reset; pc_en : advance enable (0 = stall)
//   flag_we/alu_carry/alu_zero/alu_neg : ALU flag capture
//   bus : branch request in, pc/flush/link_we/link_data out
//   flags : registered {carry, zero, neg}; taken_cnt : saturating taken-branch count
module branch_unit
    import kgp_branch_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                OFF_W       = 22,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                FORWARD     = 0,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_en,
    input  logic             flag_we,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_neg,
    branch_unit_if.slave     bus,
    output logic [2:0]       flags,
    output logic [CNT_W-1:0] taken_cnt
);
    logic [2:0]        alu_flags;
    logic [2:0]        eff;
    logic              taken;
    logic              go;
    logic [DATA_W-1:0] seq;
    logic [DATA_W-1:0] tgt;
    assign alu_flags = {alu_carry, alu_zero, alu_neg};
    // forwarding lets a compare and its dependent branch share one cycle
    assign eff = (FORWARD != 0 && flag_we) ? alu_flags : flags;
    assign seq = bus.pc + DATA_W'(INSTR_BYTES);
    assign tgt = bus.br_abs ? bus.br_reg : bus.pc + DATA_W'($signed(bus.br_off));
    assign go  = pc_en && bus.br_valid && taken;
    branch_cond u_cond (
        .cond  (bus.br_cond),
        .carry (eff[FLAG_C]),
        .zero  (eff[FLAG_Z]),
        .neg   (eff[FLAG_N]),
        .taken (taken)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc        <= RESET_PC;
            bus.flush     <= 1'b0;
            bus.link_we   <= 1'b0;
            bus.link_data <= '0;
            flags         <= '0;
            taken_cnt     <= '0;
        end else begin
            if (flag_we) flags <= alu_flags;
            if (pc_en) bus.pc <= go ? tgt : seq;
            bus.flush   <= go;
            bus.link_we <= go && bus.br_link;
            if (go && bus.br_link) bus.link_data <= seq;
            if (go && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
        end
    end
endmodule
